// File: rtl/fcl_ctrl_loader_if.sv
// Command/status bundle between the system controller and the FCL sequencer.
// master = system side issuing load commands; slave = the sequencer itself.
interface fcl_ctrl_loader_if #(
    parameter int FIELD_W = 4,
    parameter int FIELD_H = 3
);
    localparam int X_ADR_SIZE = $clog2(FIELD_W);
    localparam int Y_ADR_SIZE = $clog2(FIELD_H);

    logic                  i_cmd_load_cfg_1;
    logic                  i_cmd_load_cfg_2;
    logic                  i_FCL_allowed;
    logic [1:0]            o_cur_load_cfg_req;
    logic                  o_go;
    logic                  o_is_loading;
    logic [X_ADR_SIZE-1:0] o_cur_x;
    logic [Y_ADR_SIZE-1:0] o_cur_y;

    modport master (
        output i_cmd_load_cfg_1, i_cmd_load_cfg_2, i_FCL_allowed,
        input  o_cur_load_cfg_req, o_go, o_is_loading, o_cur_x, o_cur_y
    );

    modport slave (
        input  i_cmd_load_cfg_1, i_cmd_load_cfg_2, i_FCL_allowed,
        output o_cur_load_cfg_req, o_go, o_is_loading, o_cur_x, o_cur_y
    );
endinterface

// File: rtl/fcl_ctrl_loader.sv
// Field-configuration-load sequencer: load controller FSM plus row-major cell scanner.
// Define FCL_CMD_SYNC_EN to add 2-flop synchronizers on the load command inputs.
module fcl_ctrl_loader #(
    parameter int FIELD_W = 4,
    parameter int FIELD_H = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    fcl_ctrl_loader_if.slave  bus
);
    localparam int X_ADR_SIZE = $clog2(FIELD_W);
    localparam int Y_ADR_SIZE = $clog2(FIELD_H);
    localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

    typedef enum logic [1:0] {
        NO_REQ     = 2'd0,
        MEM_INIT   = 2'd1,
        LOAD_CFG_1 = 2'd2,
        LOAD_CFG_2 = 2'd3
    } load_cfg_req_t;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_WAIT  = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    // bit 0 = cfg_1, bit 1 = cfg_2
    logic [1:0] cmd_raw;
    logic [1:0] cmd_s;
    logic [1:0] cmd_prev_q;
    logic [1:0] cmd_rise;

    assign cmd_raw = {bus.i_cmd_load_cfg_2, bus.i_cmd_load_cfg_1};

`ifdef FCL_CMD_SYNC_EN
    logic [1:0] cmd_meta_q;
    logic [1:0] cmd_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_meta_q <= '0;
            cmd_sync_q <= '0;
        end else begin
            cmd_meta_q <= cmd_raw;
            cmd_sync_q <= cmd_meta_q;
        end
    end

    assign cmd_s = cmd_sync_q;
`else
    assign cmd_s = cmd_raw;
`endif

    assign cmd_rise = cmd_s & ~cmd_prev_q;

    state_t                state_q, state_d;
    load_cfg_req_t         req_q, req_d;
    logic                  go_q, go_d;
    logic [1:0]            pend_q, pend_d;
    logic [1:0]            pend_clr;
    logic                  is_loading_q, is_loading_d;
    logic [X_ADR_SIZE-1:0] x_q, x_d;
    logic [Y_ADR_SIZE-1:0] y_q, y_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        go_d     = 1'b0;
        pend_clr = 2'b00;
        unique case (state_q)
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!is_loading_q) begin
                    state_d = ST_IDLE;
                    req_d   = NO_REQ;
                end
            end
            ST_IDLE: begin
                req_d = NO_REQ;
                if (bus.i_FCL_allowed && pend_q[0]) begin
                    state_d  = ST_START;
                    req_d    = LOAD_CFG_1;
                    go_d     = 1'b1;
                    pend_clr = 2'b01;
                end else if (bus.i_FCL_allowed && pend_q[1]) begin
                    state_d  = ST_START;
                    req_d    = LOAD_CFG_2;
                    go_d     = 1'b1;
                    pend_clr = 2'b10;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = NO_REQ;
            end
        endcase
        // A fresh edge on the same cycle as service re-arms the request.
        pend_d = (pend_q & ~pend_clr) | cmd_rise;
    end

    always_comb begin
        is_loading_d = is_loading_q;
        x_d          = x_q;
        y_d          = y_q;
        if (is_loading_q) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d          = '0;
                    is_loading_d = 1'b0;
                end else begin
                    y_d = y_q + Y_ADR_SIZE'(1);
                end
            end else begin
                x_d = x_q + X_ADR_SIZE'(1);
            end
        end else if (go_q) begin
            is_loading_d = 1'b1;
            x_d          = '0;
            y_d          = '0;
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_START;
            req_q        <= MEM_INIT;
            go_q         <= 1'b1;
            pend_q       <= '0;
            cmd_prev_q   <= '0;
            is_loading_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            go_q         <= go_d;
            pend_q       <= pend_d;
            cmd_prev_q   <= cmd_s;
            is_loading_q <= is_loading_d;
            x_q          <= x_d;
            y_q          <= y_d;
        end
    end

    assign bus.o_cur_load_cfg_req = req_q;
    assign bus.o_go               = go_q;
    assign bus.o_is_loading       = is_loading_q;
    assign bus.o_cur_x            = x_q;
    assign bus.o_cur_y            = y_q;
endmodule

// File: tb/tb_fcl_ctrl_loader.sv
// Self-checking bench for fcl_ctrl_loader: pass-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_fcl_ctrl_loader;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;
`ifdef FCL_CMD_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fcl_ctrl_loader_if #(.FIELD_W(W), .FIELD_H(H)) bus ();
    fcl_ctrl_loader #(.FIELD_W(W), .FIELD_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a pass is GO (strobe), SCAN (cell index 0..N-1), TAIL, then IDLE.
    typedef enum int {P_GO, P_SCAN, P_TAIL, P_IDLE} phase_t;
    phase_t   m_phase = P_GO;
    int       m_req   = 1;
    int       m_idx   = 0;
    bit       m_p1 = 0, m_p2 = 0, m_prev1 = 0, m_prev2 = 0;
    bit [1:0] m_h1 = '0, m_h2 = '0;

    initial begin
        forever begin
            bit d1, d2, r1, r2, s1, s2;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = P_GO; m_req = 1; m_idx = 0;
                m_p1 = 0; m_p2 = 0; m_prev1 = 0; m_prev2 = 0;
                m_h1 = '0; m_h2 = '0;
            end else begin
                d1 = SYNC ? m_h1[1] : bus.i_cmd_load_cfg_1;
                d2 = SYNC ? m_h2[1] : bus.i_cmd_load_cfg_2;
                r1 = d1 & ~m_prev1;
                r2 = d2 & ~m_prev2;
                m_prev1 = d1;
                m_prev2 = d2;
                m_h1 = {m_h1[0], bus.i_cmd_load_cfg_1};
                m_h2 = {m_h2[0], bus.i_cmd_load_cfg_2};
                s1 = 0;
                s2 = 0;
                case (m_phase)
                    P_GO:   begin m_phase = P_SCAN; m_idx = 0; end
                    P_SCAN: begin
                        if (m_idx == N - 1) begin m_phase = P_TAIL; m_idx = 0; end
                        else m_idx++;
                    end
                    P_TAIL: begin m_phase = P_IDLE; m_req = 0; end
                    default: begin
                        if (bus.i_FCL_allowed && m_p1) begin
                            s1 = 1; m_phase = P_GO; m_req = 2;
                        end else if (bus.i_FCL_allowed && m_p2) begin
                            s2 = 1; m_phase = P_GO; m_req = 3;
                        end
                    end
                endcase
                m_p1 = (m_p1 & ~s1) | r1;
                m_p2 = (m_p2 & ~s2) | r2;
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            check("cyc_req",  32'(bus.o_cur_load_cfg_req), 32'(m_req));
            check("cyc_go",   32'(bus.o_go),               32'(m_phase == P_GO));
            check("cyc_busy", 32'(bus.o_is_loading),       32'(m_phase == P_SCAN));
            check("cyc_x",    32'(bus.o_cur_x),            32'(m_idx % W));
            check("cyc_y",    32'(bus.o_cur_y),            32'(m_idx / W));
        end
    end

    task automatic pulse(input bit c1, input bit c2);
        @(negedge clk);
        bus.i_cmd_load_cfg_1 = c1;
        bus.i_cmd_load_cfg_2 = c2;
        @(negedge clk);
        bus.i_cmd_load_cfg_1 = 1'b0;
        bus.i_cmd_load_cfg_2 = 1'b0;
    endtask

    task automatic wait_go(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.o_go) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Waits for the start strobe, then checks one full scan; optionally fires cfg_1 mid-scan.
    task automatic run_pass(input string name, input int exp_req, input int inject_at);
        bit ok;
        int cnt, lx, ly;
        wait_go(ok);
        check({name, "_go_seen"}, 32'(ok), 32'd1);
        check({name, "_req"}, 32'(bus.o_cur_load_cfg_req), 32'(exp_req));
        @(negedge clk);
        cnt = 0; lx = -1; ly = -1;
        for (int i = 0; i < 100 && bus.o_is_loading; i++) begin
            lx = int'(bus.o_cur_x);
            ly = int'(bus.o_cur_y);
            cnt++;
            bus.i_cmd_load_cfg_1 = (cnt == inject_at);
            @(negedge clk);
        end
        bus.i_cmd_load_cfg_1 = 1'b0;
        check({name, "_len"},    32'(cnt), 32'(N));
        check({name, "_last_x"}, 32'(lx),  32'(W - 1));
        check({name, "_last_y"}, 32'(ly),  32'(H - 1));
        @(negedge clk);
        check({name, "_done_req"}, 32'(bus.o_cur_load_cfg_req), 32'd0);
        check({name, "_done_go"},  32'(bus.o_go),    32'd0);
        check({name, "_done_x"},   32'(bus.o_cur_x), 32'd0);
        check({name, "_done_y"},   32'(bus.o_cur_y), 32'd0);
    endtask

    initial begin
        bit ok, busy_seen, go_seen;
        rst_n = 1'b0;
        bus.i_cmd_load_cfg_1 = 1'b0;
        bus.i_cmd_load_cfg_2 = 1'b0;
        bus.i_FCL_allowed    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req",  32'(bus.o_cur_load_cfg_req), 32'd1);
        check("rst_go",   32'(bus.o_go),               32'd1);
        check("rst_busy", 32'(bus.o_is_loading),       32'd0);
        check("rst_x",    32'(bus.o_cur_x),            32'd0);
        check("rst_y",    32'(bus.o_cur_y),            32'd0);

        rst_n = 1'b1;
        run_pass("init", 1, -1);

        bus.i_FCL_allowed = 1'b1;
        pulse(1'b1, 1'b0);
        run_pass("cfg1", 2, -1);

        bus.i_FCL_allowed = 1'b0;
        pulse(1'b1, 1'b1);
        busy_seen = 1'b0;
        go_seen   = 1'b0;
        repeat (10) begin
            @(negedge clk);
            busy_seen |= bus.o_is_loading;
            go_seen   |= bus.o_go;
        end
        check("hold_busy", 32'(busy_seen), 32'd0);
        check("hold_go",   32'(go_seen),   32'd0);
        bus.i_FCL_allowed = 1'b1;
        run_pass("dual_cfg1", 2, -1);
        run_pass("dual_cfg2", 3, -1);

        pulse(1'b0, 1'b1);
        run_pass("scan_cfg2", 3, 3);
        run_pass("queued_cfg1", 2, -1);

        pulse(1'b0, 1'b1);
        wait_go(ok);
        check("abort_go_seen", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_is_loading && bus.o_cur_x == 2 && bus.o_cur_y == 1) begin
                ok = 1'b1;
                break;
            end
        end
        check("abort_cell_seen", 32'(ok), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_req",  32'(bus.o_cur_load_cfg_req), 32'd1);
        check("abort_go",   32'(bus.o_go),               32'd1);
        check("abort_busy", 32'(bus.o_is_loading),       32'd0);
        check("abort_x",    32'(bus.o_cur_x),            32'd0);
        check("abort_y",    32'(bus.o_cur_y),            32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_pass("reinit", 1, -1);

        repeat (3) @(negedge clk);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
